// File: rtl/lcd_bus_rx.sv
// HD44780-style write-bus receiver: resynchronises the LCD strobe, decodes
// commands and data into a 2x16 character shadow buffer, and emulates busy timing.
module lcd_bus_rx #(
  parameter int unsigned CLEAR_CYC = 100000,
  parameter int unsigned CMD_CYC   = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_lcd_rs,
  input  logic       i_lcd_rw,
  input  logic       i_lcd_e,
  input  logic [7:0] i_lcd_data,
  input  logic [4:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic       o_cmd_valid,
  output logic [7:0] o_cmd,
  output logic       o_data_valid,
  output logic [4:0] o_cur_idx,
  output logic       o_disp_on,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_err
);

  localparam int unsigned MAX_CYC = (CLEAR_CYC > CMD_CYC) ? CLEAR_CYC : CMD_CYC;
  localparam int unsigned CNT_W   = ($clog2(MAX_CYC) < 5) ? 5 : $clog2(MAX_CYC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_BUSY
  } state_t;

  logic       e_s1_q, e_s2_q, e_s3_q;
  logic       rs_d1_q, rs_d2_q;
  logic       rw_d1_q, rw_d2_q;
  logic [7:0] dat_d1_q, dat_d2_q;
  logic       txn;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       cur_q, cur_d;
  logic             id_q, id_d;
  logic             disp_q, disp_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             err_q, err_d;

  logic [7:0] mem_q [32];
  logic [7:0] rd_q;
  logic       wr_en;
  logic [4:0] wr_idx;
  logic [7:0] wr_dat;

  // Cursor moves within its row only; bit 4 selects the row.
  function automatic logic [4:0] step_idx(input logic [4:0] idx, input logic inc);
    logic [3:0] col;
    col = inc ? (idx[3:0] + 4'd1) : (idx[3:0] - 4'd1);
    return {idx[4], col};
  endfunction

  // E is double-synchronised; rs/rw/data ride the same two-stage delay so they
  // line up with the synchronised strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_s1_q   <= 1'b0;
      e_s2_q   <= 1'b0;
      e_s3_q   <= 1'b0;
      rs_d1_q  <= 1'b0;
      rs_d2_q  <= 1'b0;
      rw_d1_q  <= 1'b0;
      rw_d2_q  <= 1'b0;
      dat_d1_q <= '0;
      dat_d2_q <= '0;
    end else begin
      e_s1_q   <= i_lcd_e;
      e_s2_q   <= e_s1_q;
      e_s3_q   <= e_s2_q;
      rs_d1_q  <= i_lcd_rs;
      rs_d2_q  <= rs_d1_q;
      rw_d1_q  <= i_lcd_rw;
      rw_d2_q  <= rw_d1_q;
      dat_d1_q <= i_lcd_data;
      dat_d2_q <= dat_d1_q;
    end
  end

  assign txn = e_s3_q & ~e_s2_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_d        = cur_q;
    id_d         = id_q;
    disp_d       = disp_q;
    cmd_d        = cmd_q;
    cmd_valid_d  = 1'b0;
    data_valid_d = 1'b0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = cur_q;
    wr_dat       = dat_d2_q;

    unique case (state_q)
      ST_IDLE: begin
        if (txn) begin
          if (rw_d2_q) begin
            err_d = 1'b1;
          end else if (rs_d2_q) begin
            wr_en        = 1'b1;
            data_valid_d = 1'b1;
            frame_done_d = (cur_q == 5'd31);
            cur_d        = step_idx(cur_q, id_q);
            state_d      = ST_BUSY;
            cnt_d        = CNT_W'(CMD_CYC - 1);
          end else begin
            cmd_valid_d = 1'b1;
            cmd_d       = dat_d2_q;
            state_d     = ST_BUSY;
            cnt_d       = CNT_W'(CMD_CYC - 1);
            casez (dat_d2_q)
              8'b1???_????: begin
                if (dat_d2_q[6:4] == 3'b000) begin
                  cur_d = {1'b0, dat_d2_q[3:0]};
                end else if (dat_d2_q[6:4] == 3'b100) begin
                  cur_d = {1'b1, dat_d2_q[3:0]};
                end else begin
                  err_d = 1'b1;
                end
              end
              8'b001?_????: err_d = ~(dat_d2_q[4] & dat_d2_q[3]);
              8'b0000_1???: disp_d = dat_d2_q[2];
              8'b0000_01??: id_d = dat_d2_q[1];
              8'b0000_001?: begin
                cur_d = '0;
                cnt_d = CNT_W'(CLEAR_CYC - 1);
              end
              8'b0000_0001: begin
                cur_d   = '0;
                id_d    = 1'b1;
                state_d = ST_CLEAR;
                cnt_d   = '0;
              end
              default: ;
            endcase
          end
        end
      end

      // The low counter bits double as the fill index while clearing.
      ST_CLEAR: begin
        err_d  = txn;
        wr_en  = 1'b1;
        wr_idx = cnt_q[4:0];
        wr_dat = 8'h20;
        if (cnt_q[4:0] == 5'd31) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(CLEAR_CYC - 33);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_BUSY: begin
        err_d = txn;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cur_q        <= '0;
      id_q         <= 1'b1;
      disp_q       <= 1'b0;
      cmd_q        <= '0;
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      id_q         <= id_d;
      disp_q       <= disp_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      data_valid_q <= data_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  // Read samples the pre-write contents, so a same-cycle write is not seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        mem_q[i] <= 8'h20;
      end
      rd_q <= 8'h20;
    end else begin
      if (wr_en) begin
        mem_q[wr_idx] <= wr_dat;
      end
      rd_q <= mem_q[i_rd_addr];
    end
  end

  assign o_rd_data    = rd_q;
  assign o_cmd_valid  = cmd_valid_q;
  assign o_cmd        = cmd_q;
  assign o_data_valid = data_valid_q;
  assign o_cur_idx    = cur_q;
  assign o_disp_on    = disp_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_done = frame_done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Scoreboard bench for lcd_bus_rx: a behavioural LCD model predicts every pulse
// and the shadow buffer; a monitor matches DUT pulses against the queue.
module tb_lcd_bus_rx;
  localparam int CLR = 64;
  localparam int CMD = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       cmd_valid, data_valid, disp_on, busy, frame_done, err;
  logic [7:0] cmd;
  logic [4:0] cur_idx;

  always #5 clk = ~clk;

  lcd_bus_rx #(.CLEAR_CYC(CLR), .CMD_CYC(CMD)) dut (
    .clk(clk), .rst(rst),
    .i_lcd_rs(lcd_rs), .i_lcd_rw(lcd_rw), .i_lcd_e(lcd_e), .i_lcd_data(lcd_data),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_cmd_valid(cmd_valid), .o_cmd(cmd), .o_data_valid(data_valid),
    .o_cur_idx(cur_idx), .o_disp_on(disp_on), .o_busy(busy),
    .o_frame_done(frame_done), .o_err(err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit  cv, dv, fd, er;
    int  cmd, cur, disp, at;
  } exp_t;
  exp_t q[$];

  // Reference model of the emulated controller
  int mbuf[32];
  int mcur, mid, mdisp, mcmd, busy_end;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mbuf[i] = 'h20;
    mcur = 0; mid = 1; mdisp = 0; mcmd = 0;
    busy_end = cyc;
  endtask

  task automatic model_txn(input int rs, input int rw, input int d8, input int dcyc);
    exp_t e;
    int a, col;
    e = '{default: 0};
    e.at = dcyc;
    if (dcyc - 1 <= busy_end) e.er = 1;
    else if (rw != 0) e.er = 1;
    else if (rs != 0) begin
      mbuf[mcur] = d8;
      e.dv = 1;
      e.fd = (mcur == 31);
      col = (mid != 0) ? (mcur % 16 + 1) % 16 : (mcur % 16 + 15) % 16;
      mcur = (mcur / 16) * 16 + col;
      busy_end = dcyc + CMD - 1;
    end else begin
      e.cv = 1;
      mcmd = d8;
      busy_end = dcyc + CMD - 1;
      if (d8 == 1) begin
        mcur = 0; mid = 1; busy_end = dcyc + CLR - 1;
        for (int i = 0; i < 32; i++) mbuf[i] = 'h20;
      end else if (d8 == 2 || d8 == 3) begin
        mcur = 0; busy_end = dcyc + CLR - 1;
      end else if (d8 >= 4 && d8 <= 7) mid = (d8 >> 1) & 1;
      else if (d8 >= 8 && d8 <= 15) mdisp = (d8 >> 2) & 1;
      else if (d8 >= 'h20 && d8 <= 'h3F) e.er = ((d8 & 'h18) != 'h18);
      else if (d8 >= 'h80) begin
        a = d8 - 'h80;
        if (a < 16) mcur = a;
        else if (a >= 'h40 && a < 'h50) mcur = 16 + a - 'h40;
        else e.er = 1;
      end
    end
    e.cmd = mcmd; e.cur = mcur; e.disp = mdisp;
    q.push_back(e);
  endtask

  // Strobe E high for 3 cycles, drop it, then idle for gap cycles.
  task automatic txn(input int rs, input int rw, input int d8, input int gap);
    @(negedge clk);
    lcd_rs = rs[0]; lcd_rw = rw[0]; lcd_data = d8[7:0]; lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    lcd_e = 1'b0;
    model_txn(rs, rw, d8, cyc + 3);
    repeat (gap) @(negedge clk);
  endtask

  task automatic readback();
    while (cyc <= busy_end + 1) @(negedge clk);
    check("busy_idle", int'(busy), 0);
    for (int i = 0; i < 32; i++) begin
      rd_addr = i[4:0];
      @(negedge clk);
      @(negedge clk);
      check($sformatf("rd[%0d]", i), int'(rd_data), mbuf[i]);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (cmd_valid || data_valid || frame_done || err)) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse: got cv=%0b dv=%0b fd=%0b er=%0b expected none (cycle %0d)",
                 cmd_valid, data_valid, frame_done, err, cyc);
      end else begin
        e = q.pop_front();
        check("pulse_cycle", cyc, e.at);
        check("cmd_valid", int'(cmd_valid), int'(e.cv));
        check("data_valid", int'(data_valid), int'(e.dv));
        check("frame_done", int'(frame_done), int'(e.fd));
        check("err", int'(err), int'(e.er));
        check("cmd", int'(cmd), e.cmd);
        check("cur_idx", int'(cur_idx), e.cur);
        check("disp_on", int'(disp_on), e.disp);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, d8, rs, rw;
    rst = 1'b1; lcd_rs = 0; lcd_rw = 0; lcd_e = 0; lcd_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_cmd", int'(cmd), 0);
    check("rst_cur", int'(cur_idx), 0);
    check("rst_disp", int'(disp_on), 0);
    check("rst_rd", int'(rd_data), 'h20);
    rst = 1'b0;
    model_reset();

    // Power-up init sequence
    txn(0, 0, 'h38, CLR + 4);
    txn(0, 0, 'h0C, CLR + 4);
    txn(0, 0, 'h06, CLR + 4);
    txn(0, 0, 'h01, CLR + 4);
    readback();

    // Fill both rows
    txn(0, 0, 'h80, CMD + 2);
    for (int i = 0; i < 16; i++) txn(1, 0, 'h4F, CMD + 2);
    txn(0, 0, 'hC0, CMD + 2);
    for (int i = 0; i < 16; i++) txn(1, 0, 'h4F, CMD + 2);
    readback();

    // Addressed write, row wrap both directions
    txn(0, 0, 'hC5, CMD + 2);
    txn(1, 0, 'h41, CMD + 2);
    txn(0, 0, 'h8F, CMD + 2);
    txn(1, 0, 'h42, CMD + 2);
    txn(0, 0, 'h04, CMD + 2);
    txn(0, 0, 'h80, CMD + 2);
    txn(1, 0, 'h43, CMD + 2);
    txn(0, 0, 'h90, CMD + 2);
    txn(0, 0, 'h06, CMD + 2);
    readback();

    // Write during clear, read strobe, then busy-expiry boundary
    txn(0, 0, 'h01, 10);
    txn(1, 0, 'h55, CLR + 4);
    txn(1, 1, 'h66, CMD + 2);
    txn(1, 0, 'h31, CMD - 4);
    txn(1, 0, 'h32, CMD - 3);
    txn(1, 0, 'h33, CMD + 2);
    readback();

    // Reset in the middle of a clear
    txn(0, 0, 'h01, 13);
    check("clear_busy", int'(busy), 1);
    check("queue_drained", q.size(), 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_cur", int'(cur_idx), 0);
    check("midrst_cmd", int'(cmd), 0);
    check("midrst_rd", int'(rd_data), 'h20);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    txn(1, 0, 'h5A, CMD + 2);
    readback();

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      rs = 0; rw = 0;
      if (r < 8) begin
        rw = 1; rs = $urandom_range(0, 1); d8 = $urandom_range(0, 255);
      end else if (r < 55) begin
        rs = 1; d8 = $urandom_range(0, 255);
      end else if (r < 58) d8 = $urandom_range(1, 3);
      else if (r < 65) d8 = $urandom_range(4, 7);
      else if (r < 72) d8 = $urandom_range(8, 15);
      else if (r < 80) d8 = $urandom_range('h20, 'h3F);
      else if (r < 95) d8 = $urandom_range('h80, 'hFF);
      else d8 = $urandom_range('h10, 'h7F);
      txn(rs, rw, d8, $urandom_range(1, CMD + 6));
      if (n % 60 == 59) readback();
    end
    readback();
    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
